// File: rtl/ber_seq_pkg.sv
// Shared types and sizing helpers for the BER sweep sequencer.
package ber_seq_pkg;

    localparam int unsigned DEF_COUNT_WIDTH    = 32;
    localparam int unsigned DEF_RESET_CYCLES   = 4;
    localparam int unsigned DEF_WARMUP_CYCLES  = 64;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_WARMUP,
        ST_BASELINE,
        ST_RUN,
        ST_REPORT,
        ST_DONE
    } state_t;

    // Down-counter width able to hold the largest of the three phase lengths.
    function automatic int unsigned tmr_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    localparam int unsigned TMR_WIDTH =
        tmr_width(DEF_RESET_CYCLES, DEF_WARMUP_CYCLES, DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/ber_seq_timer.sv
// Loadable down-counter shared by the reset, warm-up and watchdog phases.
module ber_seq_timer
    import ber_seq_pkg::*;
#(
    parameter int unsigned WIDTH = TMR_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_expired_c
);

    logic [WIDTH-1:0] r_count;

    // Count down to zero and hold there until reloaded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired_c = (r_count == '0);

endmodule

// File: rtl/ber_sweep_sequencer.sv
// Steps the noise setting through all points, measuring bits/errors per point
// over a programmable window and returning one record per point.
module ber_sweep_sequencer
    import ber_seq_pkg::*;
#(
    parameter int unsigned NUM_POINTS     = 8,
    parameter int unsigned SEL_WIDTH      = 3,
    parameter int unsigned RESET_CYCLES   = 4,
    parameter int unsigned WARMUP_CYCLES  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned COUNT_WIDTH    = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [COUNT_WIDTH-1:0] target_bits,
    input  logic [COUNT_WIDTH-1:0] total_bits,
    input  logic [COUNT_WIDTH-1:0] total_bit_errors,
    output logic                   chain_rstn,
    output logic                   chain_en,
    output logic [SEL_WIDTH-1:0]   noise_sel,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [SEL_WIDTH-1:0]   result_sel,
    output logic [COUNT_WIDTH-1:0] result_bits,
    output logic [COUNT_WIDTH-1:0] result_errors,
    output logic                   result_timeout,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned TW = tmr_width(RESET_CYCLES, WARMUP_CYCLES, TIMEOUT_CYCLES);
    localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_POINTS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [COUNT_WIDTH-1:0] r_target;
    logic [COUNT_WIDTH-1:0] r_base_bits;
    logic [COUNT_WIDTH-1:0] r_base_err;
    logic [COUNT_WIDTH-1:0] r_prev_bits;
    logic [COUNT_WIDTH-1:0] w_meas_bits;
    logic [COUNT_WIDTH-1:0] w_meas_err;
    logic                   w_hit_target;
    logic                   w_bits_changed;
    logic                   w_tmr_load;
    logic [TW-1:0]          w_tmr_val;
    logic                   w_tmr_expired;
    logic                   w_chain_rstn_nxt;
    logic                   w_chain_en_nxt;
    logic                   w_valid_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;

    // Window arithmetic is modulo 2^COUNT_WIDTH so counter wrap is harmless.
    assign w_meas_bits    = total_bits - r_base_bits;
    assign w_meas_err     = total_bit_errors - r_base_err;
    assign w_hit_target   = (w_meas_bits >= r_target);
    assign w_bits_changed = (total_bits != r_prev_bits);

    ber_seq_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk         (clk),
        .rstn        (rstn),
        .i_load      (w_tmr_load),
        .i_value     (w_tmr_val),
        .o_expired_c (w_tmr_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and timer reloads; abort overrides everything outside IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RESET;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(RESET_CYCLES - 1);
                end
            end
            ST_RESET: begin
                if (w_tmr_expired) begin
                    w_state_nxt = ST_WARMUP;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(WARMUP_CYCLES - 1);
                end
            end
            ST_WARMUP: begin
                if (w_tmr_expired) begin
                    w_state_nxt = ST_BASELINE;
                end
            end
            ST_BASELINE: begin
                w_state_nxt = ST_RUN;
                w_tmr_load  = 1'b1;
                w_tmr_val   = TW'(TIMEOUT_CYCLES - 1);
            end
            ST_RUN: begin
                if (w_hit_target || w_tmr_expired) begin
                    w_state_nxt = ST_REPORT;
                end else if (w_bits_changed) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TW'(TIMEOUT_CYCLES - 1);
                end
            end
            ST_REPORT: begin
                if (result_ready) begin
                    if (noise_sel == LAST_SEL) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RESET;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TW'(RESET_CYCLES - 1);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Output values for the state being entered, registered below.
    always_comb begin
        w_chain_rstn_nxt = 1'b0;
        w_chain_en_nxt   = 1'b0;
        w_valid_nxt      = 1'b0;
        w_busy_nxt       = 1'b1;
        w_done_nxt       = 1'b0;
        case (w_state_nxt)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
            end
            ST_WARMUP, ST_BASELINE, ST_RUN: begin
                w_chain_rstn_nxt = 1'b1;
                w_chain_en_nxt   = 1'b1;
            end
            ST_REPORT: begin
                w_chain_rstn_nxt = 1'b1;
                w_valid_nxt      = 1'b1;
            end
            ST_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain_rstn     <= 1'b0;
            chain_en       <= 1'b0;
            result_valid   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            noise_sel      <= '0;
            result_sel     <= '0;
            result_bits    <= '0;
            result_errors  <= '0;
            result_timeout <= 1'b0;
            r_target       <= '0;
            r_base_bits    <= '0;
            r_base_err     <= '0;
            r_prev_bits    <= '0;
        end else begin
            chain_rstn   <= w_chain_rstn_nxt;
            chain_en     <= w_chain_en_nxt;
            result_valid <= w_valid_nxt;
            busy         <= w_busy_nxt;
            done         <= w_done_nxt;
            r_prev_bits  <= total_bits;
            if ((r_state == ST_IDLE) && (w_state_nxt == ST_RESET)) begin
                r_target  <= target_bits;
                noise_sel <= '0;
            end
            if (r_state == ST_BASELINE) begin
                r_base_bits <= total_bits;
                r_base_err  <= total_bit_errors;
            end
            // Target wins over a same-cycle watchdog expiry.
            if ((r_state == ST_RUN) && (w_state_nxt == ST_REPORT)) begin
                result_sel     <= noise_sel;
                result_bits    <= w_meas_bits;
                result_errors  <= w_meas_err;
                result_timeout <= ~w_hit_target;
            end
            if ((r_state == ST_REPORT) && (w_state_nxt == ST_RESET)) begin
                noise_sel <= noise_sel + SEL_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ber_sweep_sequencer.sv
// Directed sweeps with randomized checker-counter traffic; expected records are
// derived from the recorded counter history and the sequencing rules.
`timescale 1ns/1ps
module tb_ber_sweep_sequencer;

    localparam int unsigned NP = 4;
    localparam int unsigned SW = 3;
    localparam int unsigned RC = 4;
    localparam int unsigned WC = 8;
    localparam int unsigned TC = 16;
    localparam int unsigned CW = 32;
    localparam int          MAXC = 16384;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          abort;
    logic [CW-1:0] target_bits;
    logic [CW-1:0] total_bits;
    logic [CW-1:0] total_bit_errors;
    logic          chain_rstn;
    logic          chain_en;
    logic [SW-1:0] noise_sel;
    logic          result_valid;
    logic          result_ready;
    logic [SW-1:0] result_sel;
    logic [CW-1:0] result_bits;
    logic [CW-1:0] result_errors;
    logic          result_timeout;
    logic          busy;
    logic          done;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int mode     = 0;   // 0 ideal, 1 +1 per cycle, 2 frozen, 3 noisy with errors
    logic [CW-1:0] hist_b [MAXC];
    logic [CW-1:0] hist_e [MAXC];

    ber_sweep_sequencer #(
        .NUM_POINTS     (NP),
        .SEL_WIDTH      (SW),
        .RESET_CYCLES   (RC),
        .WARMUP_CYCLES  (WC),
        .TIMEOUT_CYCLES (TC),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .start            (start),
        .abort            (abort),
        .target_bits      (target_bits),
        .total_bits       (total_bits),
        .total_bit_errors (total_bit_errors),
        .chain_rstn       (chain_rstn),
        .chain_en         (chain_en),
        .noise_sel        (noise_sel),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_sel       (result_sel),
        .result_bits      (result_bits),
        .result_errors    (result_errors),
        .result_timeout   (result_timeout),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the checker counters advance only while the chain is enabled.
    task automatic tick();
        logic [CW-1:0] inc;
        logic [CW-1:0] einc;
        @(posedge clk);
        #1;
        cyc++;
        inc  = '0;
        einc = '0;
        if (chain_en === 1'b1) begin
            case (mode)
                0: inc = CW'($urandom_range(4, 1));
                1: inc = CW'(1);
                3: begin
                    inc  = CW'($urandom_range(4, 1));
                    einc = CW'($urandom_range(1, 0));
                end
                default: inc = '0;
            endcase
        end
        total_bits       = total_bits + inc;
        total_bit_errors = total_bit_errors + einc;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget observed=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "history overflow");
        end
        hist_b[cyc] = total_bits;
        hist_e[cyc] = total_bit_errors;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic set_bits(input logic [CW-1:0] v);
        total_bits  = v;
        hist_b[cyc] = v;
    endtask

    // Reference: window opens at baseline cycle b, closes on target or after TC unchanged cycles.
    task automatic model_point(input int b, input logic [CW-1:0] tgt, output int e,
                               output logic [CW-1:0] mb, output logic [CW-1:0] me,
                               output logic mto);
        int stall;
        e = -1; mb = '0; me = '0; mto = 1'b0; stall = 0;
        for (int j = b + 1; j < cyc && e < 0; j++) begin
            logic [CW-1:0] d;
            d = hist_b[j] - hist_b[b];
            stall++;
            if (d >= tgt) begin
                e = j; mb = d; me = hist_e[j] - hist_e[b]; mto = 1'b0;
            end else if (stall >= int'(TC)) begin
                e = j; mb = d; me = hist_e[j] - hist_e[b]; mto = 1'b1;
            end else if (hist_b[j] != hist_b[j-1]) begin
                stall = 0;
            end
        end
    endtask

    task automatic do_start(input logic [CW-1:0] tgt, output int p);
        target_bits = tgt;
        start = 1'b1;
        tick();
        start = 1'b0;
        p = cyc;
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_chain", 64'({chain_en, chain_rstn}), 64'(0));
        chk("start_sel", 64'(noise_sel), 64'(0));
    endtask

    // One point starting with RESET at cycle p; returns the accept cycle.
    task automatic run_point(input int p, input logic [SW-1:0] sel, input logic [CW-1:0] tgt,
                             input bit tied, input int delay, input bit poke_start,
                             input bit abort_rep, output int a);
        int n, e, b;
        logic [CW-1:0] mb, me;
        logic mto;
        b = p + int'(RC) + int'(WC);
        n = 0;
        do begin
            tick();
            n++;
            if (!tied) result_ready = 1'b0;
            if (cyc == p + int'(RC) - 1) chk("pre_enable", 64'({chain_en, chain_rstn}), 64'(0));
            if (cyc == p + int'(RC))     chk("first_enable", 64'({chain_en, chain_rstn}), 64'(3));
            if (poke_start && cyc == p + 3) begin start = 1'b1; target_bits = '0; end
            if (poke_start && cyc == p + 4) start = 1'b0;
        end while (result_valid !== 1'b1 && n < 3000);
        a = cyc;
        if (result_valid !== 1'b1) begin
            chk("valid_wait", 64'(result_valid), 64'(1));
            return;
        end
        model_point(b, tgt, e, mb, me, mto);
        chk("valid_time", 64'(cyc), 64'(e + 1));
        chk("rec_sel", 64'(result_sel), 64'(sel));
        chk("rec_bits", 64'(result_bits), 64'(mb));
        chk("rec_errors", 64'(result_errors), 64'(me));
        chk("rec_timeout", 64'(result_timeout), 64'(mto));
        chk("report_en", 64'(chain_en), 64'(0));
        for (int k = 0; k < delay; k++) begin
            tick();
            chk("bp_valid", 64'(result_valid), 64'(1));
            chk("bp_bits", 64'(result_bits), 64'(mb));
            chk("bp_errors", 64'(result_errors), 64'(me));
            chk("bp_sel", 64'(result_sel), 64'(sel));
            chk("bp_en", 64'(chain_en), 64'(0));
        end
        if (abort_rep) begin
            abort = 1'b1;
            result_ready = 1'b1;
            tick();
            abort = 1'b0;
            result_ready = 1'b0;
            chk("abort_rep_valid", 64'(result_valid), 64'(0));
            chk("abort_rep_busy", 64'(busy), 64'(0));
            chk("abort_rep_done", 64'(done), 64'(0));
        end else begin
            result_ready = 1'b1;
        end
        a = cyc;
    endtask

    task automatic sweep(input logic [CW-1:0] tgt, input bit tied, input int bp_point,
                         input int bp_delay, input bit poke);
        int p, a, d0;
        d0 = done_cnt;
        do_start(tgt, p);
        for (int i = 0; i < int'(NP); i++) begin
            run_point(p, SW'(i), tgt, tied, (i == bp_point) ? bp_delay : 0,
                      poke && (i == 1), 1'b0, a);
            p = a + 1;
        end
        tick();
        if (!tied) result_ready = 1'b0;
        chk("done_pulse", 64'(done), 64'(1));
        chk("done_valid", 64'(result_valid), 64'(0));
        tick();
        chk("done_clear", 64'(done), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("final_sel", 64'(noise_sel), 64'(NP - 1));
        chk("done_count", 64'(done_cnt), 64'(d0 + 1));
    endtask

    initial begin
        int p, a, d0, b;
        rstn = 1'b0; start = 1'b0; abort = 1'b0; result_ready = 1'b0;
        target_bits = '0; total_bits = '0; total_bit_errors = '0;
        hist_b[0] = '0; hist_e[0] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_chain", 64'({chain_rstn, chain_en}), 64'(0));
        chk("rst_valid", 64'(result_valid), 64'(0));
        chk("rst_busy_done", 64'({busy, done}), 64'(0));
        chk("rst_sel", 64'(noise_sel), 64'(0));
        rstn = 1'b1;

        // Ideal chain, ready tied high.
        mode = 0;
        result_ready = 1'b1;
        sweep(CW'(1000), 1'b1, -1, 0, 1'b0);

        // Errors present, 50-cycle backpressure on point 1, start pulsed while busy.
        mode = 3;
        result_ready = 1'b0;
        sweep(CW'(300), 1'b0, 1, 50, 1'b1);

        // Counter wrap across the measurement window.
        mode = 1;
        set_bits(32'hFFFF_FF00);
        result_ready = 1'b1;
        sweep(CW'(512), 1'b1, -1, 0, 1'b0);

        // Frozen counter: watchdog ends the window, then abort beats a same-cycle accept.
        mode = 2;
        result_ready = 1'b0;
        d0 = done_cnt;
        do_start(CW'(1000), p);
        run_point(p, SW'(0), CW'(1000), 1'b0, 0, 1'b0, 1'b1, a);
        chk("stall_no_done", 64'(done_cnt), 64'(d0));

        // Abort in WARMUP of point 2.
        mode = 0;
        d0 = done_cnt;
        do_start(CW'(20), p);
        run_point(p, SW'(0), CW'(20), 1'b0, 0, 1'b0, 1'b0, a);
        p = a + 1;
        run_point(p, SW'(1), CW'(20), 1'b0, 0, 1'b0, 1'b0, a);
        p = a + 1;
        tick();
        result_ready = 1'b0;
        while (cyc < p + int'(RC) + 2) tick();
        chk("warmup_state", 64'({chain_en, noise_sel}), 64'({1'b1, 3'd2}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_chain", 64'({chain_en, chain_rstn}), 64'(0));
        chk("abort_valid", 64'(result_valid), 64'(0));
        repeat (5) tick();
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        chk("abort_idle", 64'(busy), 64'(0));

        // Zero target: each window closes on its first RUN cycle, minimum point cost.
        result_ready = 1'b1;
        sweep(CW'(0), 1'b1, -1, 0, 1'b0);

        // Asynchronous reset in the middle of RUN.
        result_ready = 1'b0;
        do_start(CW'(1000), p);
        b = p + int'(RC) + int'(WC);
        while (cyc < b + 3) tick();
        chk("run_active", 64'({busy, chain_en}), 64'(3));
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_chain", 64'({chain_rstn, chain_en}), 64'(0));
        chk("arst_busy_done", 64'({busy, done}), 64'(0));
        chk("arst_valid", 64'(result_valid), 64'(0));
        chk("arst_sel", 64'({noise_sel, result_sel}), 64'(0));
        chk("arst_bits", 64'(result_bits), 64'(0));
        chk("arst_errors", 64'(result_errors), 64'(0));
        chk("arst_timeout", 64'(result_timeout), 64'(0));
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_idle", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ber_sweep_sequencer.md
# ber_sweep_sequencer

Test-sequencing controller for the PRBS31 → grey/PAM-4 → ISI channel → noise → DFE → PAM-4 decode → PRBS31-checker chain. It steps the noise-injection setting through `NUM_POINTS` indices. For each point it:
- soft-resets and enables the chain,
- lets the pipeline fill,
- measures bits and bit errors from the checker counters over a programmable window,
- returns one result record per point over a valid/ready handshake.

## Interface
Parameters:
- `NUM_POINTS`, 8: number of noise settings swept, indices 0..NUM_POINTS-1.
- `SEL_WIDTH`, 3: width of `noise_sel`; must satisfy 2^SEL_WIDTH ≥ NUM_POINTS.
- `RESET_CYCLES`, 4: cycles `chain_rstn` is held low per point.
- `WARMUP_CYCLES`, 64: cycles `chain_en`=1 before the measurement baseline is taken.
- `TIMEOUT_CYCLES`, 1024: cycles without `total_bits` change before RUN aborts the point.
- `COUNT_WIDTH`, 32: width of checker counters and results.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: asynchronous active-low reset.
- `start` in 1: begin sweep; sampled only in IDLE.
- `abort` in 1: cancel sweep from any state.
- `target_bits` in COUNT_WIDTH: measurement window length in bits; sampled at `start`.
- `total_bits` in COUNT_WIDTH: checker running bit count.
- `total_bit_errors` in COUNT_WIDTH: checker running error count.
- `chain_rstn` out 1: active-low soft reset driven to every chain block.
- `chain_en` out 1: chain enable (PRBS and noise).
- `noise_sel` out SEL_WIDTH: current noise setting index.
- `result_valid` out 1: result record valid.
- `result_ready` in 1: consumer accepts the record.
- `result_sel` out SEL_WIDTH: noise index of the record.
- `result_bits` out COUNT_WIDTH: bits measured in the window.
- `result_errors` out COUNT_WIDTH: errors measured in the window.
- `result_timeout` out 1: window ended by watchdog, not by target.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the sweep completes.

## Operation
States are IDLE, RESET, WARMUP, BASELINE, RUN, REPORT, DONE.

- **IDLE**
  - Outputs: `chain_rstn`=0, `chain_en`=0.
  - On `start`=1: latch `target_bits`, set `noise_sel`=0, go to RESET.
- **RESET**
  - Outputs: `chain_rstn`=0, `chain_en`=0.
  - Hold exactly RESET_CYCLES cycles, then go to WARMUP.
- **WARMUP**
  - Outputs: `chain_rstn`=1, `chain_en`=1.
  - Hold exactly WARMUP_CYCLES cycles, then go to BASELINE.
- **BASELINE**
  - One cycle. Register `base_bits`=`total_bits` and `base_err`=`total_bit_errors`.
  - Clear the watchdog, then go to RUN.
- **RUN**
  - Every cycle compute `meas_bits`=`total_bits`−`base_bits` and `meas_err`=`total_bit_errors`−`base_err`.
  - Both subtractions are modulo 2^COUNT_WIDTH, so counter wrap is handled.
  - Exit when `meas_bits` ≥ latched target: set `result_timeout`=0.
  - Exit when the watchdog reaches TIMEOUT_CYCLES: set `result_timeout`=1.
  - If both exit conditions hold in the same cycle, target wins (`result_timeout`=0).
  - On exit, latch `result_*` from that cycle's values and go to REPORT.
  - The watchdog reloads whenever `total_bits` differs from its previous-cycle value.
- **REPORT**
  - `chain_en`=0; the chain is frozen and not reset.
  - Hold `result_valid`=1 with stable payload until `result_ready`=1.
  - On acceptance, if `noise_sel`=NUM_POINTS−1 go to DONE; otherwise increment `noise_sel` and go to RESET.
- **DONE**
  - Pulse `done`=1, go to IDLE. `noise_sel` keeps its final value.
- **Abort**
  - `abort`=1 in any non-IDLE state → IDLE next cycle.
  - `result_valid` drops, `chain_en`=0, no `done` pulse.
  - Abort has priority over every other transition, including a same-cycle handshake.
- **`target_bits`=0**
  - RUN exits on its first cycle with `result_bits`=`meas_bits` at that cycle (≥0).
- **`start` while busy**: ignored.

## Timing
- **Reset values** (`rstn` low): state IDLE, `chain_rstn`=0, `chain_en`=0, `noise_sel`=0, `result_valid`=0, all `result_*`=0, `busy`=0, `done`=0.
- **Registered outputs**: all outputs are registered and change only on `clk` rising edge.
- **Start latency**: `start` high at edge N gives `busy`=1 and `chain_rstn`=0 from N+1.
- **First enable**: `chain_en` first rises at N+1+RESET_CYCLES.
- **Baseline cycle**: the baseline is sampled at cycle N+1+RESET_CYCLES+WARMUP_CYCLES.
- **Handshake**: transfer occurs on an edge with `result_valid`&&`result_ready`.
- **After transfer**: `result_valid` is 0 the next cycle. Back-to-back records are separated by at least RESET_CYCLES+WARMUP_CYCLES+2 cycles.
- **Point cost**: minimum point duration is RESET_CYCLES+WARMUP_CYCLES+3 cycles when `result_ready` is held high.

## Structure
- **Package `ber_seq_pkg`**:
  - `state_t` enum for the seven states.
  - Default `COUNT_WIDTH`.
  - Localparam for the down-counter width: $clog2 of max(RESET_CYCLES, WARMUP_CYCLES, TIMEOUT_CYCLES)+1.
- **Sub-module `ber_seq_timer`**:
  - Loadable down-counter with `load`, `value`, and `expired` outputs.
  - Shared by RESET, WARMUP and the RUN watchdog.
  - The FSM and window arithmetic stay in the top level.

## Test plan
- **Full sweep, zero errors**: ideal chain, NUM_POINTS=4, `target_bits`=1000, `result_ready` tied 1 → 4 records with `result_sel` 0,1,2,3, `result_bits`≥1000, `result_errors`=0, `result_timeout`=0, then one `done` pulse.
- **Backpressure**: `result_ready` held 0 for 50 cycles in REPORT → `result_valid` and payload stable all 50 cycles, `chain_en`=0, exactly one record transferred.
- **Counter wrap**: model drives `total_bits` from 0xFFFF_FF00 upward by 1 per cycle, `target_bits`=512 → `result_bits`=512 with no wrap error.
- **Stalled counter**: `total_bits` frozen during RUN, TIMEOUT_CYCLES=16 → record 17 cycles after BASELINE with `result_timeout`=1 and `result_bits`=0.
- **Abort mid-point**: `abort` pulsed in WARMUP of point 2 → next cycle IDLE, `busy`=0, `chain_en`=0, no `done`; a new `start` restarts at `noise_sel`=0.
- **Reset mid-run**: `rstn` asserted in RUN → all outputs at reset values immediately, asynchronously.
